// File: rtl/ycr_dmem_sram_wbs_pkg.sv
// Shared Wishbone definitions for the dmem SRAM slave: burst width, FSM encoding
// and the address-window hit check.
package ycr_wb;

    localparam int YCR_WB_BL_DMEM = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_WR_ISS = 3'd2,
        ST_WR_ACK = 3'd3,
        ST_ERR    = 3'd4
    } type_ycr_sram_wbs_fsm_e;

    function automatic logic ycr_wb_win_hit(input logic [31:0] adr,
                                            input logic [31:0] base,
                                            input logic [31:0] mask);
        return (adr & mask) == base;
    endfunction

endpackage

// File: rtl/ycr_sram_rd_pipe.sv
// Read return stage: tracks which cycle carries SRAM data and whether it is the
// final beat, and gates sram_dout onto the bus only in that cycle.
module ycr_sram_rd_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_issue,
    input  logic        i_last,
    input  logic [31:0] i_sram_dout,
    output logic        o_ack,
    output logic        o_lack,
    output logic [31:0] o_dat
);

    logic r_vld;
    logic r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else begin
            r_vld  <= i_issue;
            r_last <= i_issue & i_last;
        end
    end

    assign o_ack  = r_vld;
    assign o_lack = r_vld & r_last;
    assign o_dat  = r_vld ? i_sram_dout : 32'h0;

endmodule

// File: rtl/ycr_dmem_sram_wbs.sv
// Wishbone burst slave mapping dmem bursts onto a single-port SRAM with
// 1-cycle read latency; out-of-window requests get a one-beat error response.
//
// state     | meaning
// ST_IDLE   | waiting for stb, decode window, latch start word and beat count
// ST_RD     | issue one read per bry cycle, acks trail issues by one cycle
// ST_WR_ISS | write current beat to SRAM once bry is high
// ST_WR_ACK | ack the written beat, lack on the final one
// ST_ERR    | single ack+lack+err beat, no SRAM access
module ycr_dmem_sram_wbs
    import ycr_wb::*;
#(
    parameter int          SRAM_AW   = 9,
    parameter logic [31:0] BASE_ADDR = 32'h0C00_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_F800
) (
    input  logic                      wb_clk,
    input  logic                      wb_rst_n,
    input  logic                      wbs_stb_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic                      wbs_we_i,
    input  logic [31:0]               wbs_dat_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [YCR_WB_BL_DMEM-1:0] wbs_bl_i,
    input  logic                      wbs_bry_i,
    output logic [31:0]               wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic                      wbs_lack_o,
    output logic                      wbs_err_o,
    output logic                      sram_csb,
    output logic                      sram_web,
    output logic [3:0]                sram_wmask,
    output logic [SRAM_AW-1:0]        sram_addr,
    output logic [31:0]               sram_din,
    input  logic [31:0]               sram_dout
);

    localparam logic [SRAM_AW-1:0]        AW_ONE = 1;
    localparam logic [YCR_WB_BL_DMEM-1:0] BL_ONE = 1;

    type_ycr_sram_wbs_fsm_e r_state;
    type_ycr_sram_wbs_fsm_e w_next;

    logic [SRAM_AW-1:0]        r_addr_cnt;
    logic [YCR_WB_BL_DMEM-1:0] r_left;
    logic                      r_ack;
    logic                      r_lack;
    logic                      r_err;

    logic        w_hit;
    logic        w_rd_issue;
    logic        w_wr_issue;
    logic        w_last_beat;
    logic        w_rd_ack;
    logic        w_rd_lack;
    logic [31:0] w_rd_dat;

    assign w_hit       = ycr_wb_win_hit(wbs_adr_i, BASE_ADDR, ADDR_MASK);
    assign w_last_beat = (r_left == BL_ONE);

    always_comb begin
        w_next     = r_state;
        w_rd_issue = 1'b0;
        w_wr_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (wbs_stb_i) begin
                    if (!w_hit)        w_next = ST_ERR;
                    else if (wbs_we_i) w_next = ST_WR_ISS;
                    else               w_next = ST_RD;
                end
            end
            ST_RD: begin
                if (!wbs_stb_i) begin
                    w_next = ST_IDLE;
                end else begin
                    w_rd_issue = wbs_bry_i && (r_left != '0);
                    if (w_rd_lack) w_next = ST_IDLE;
                end
            end
            ST_WR_ISS: begin
                if (!wbs_stb_i) begin
                    w_next = ST_IDLE;
                end else if (wbs_bry_i) begin
                    w_wr_issue = 1'b1;
                    w_next     = ST_WR_ACK;
                end
            end
            ST_WR_ACK: begin
                if (!wbs_stb_i || r_lack) w_next = ST_IDLE;
                else                      w_next = ST_WR_ISS;
            end
            ST_ERR:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // r_left counts beats still to issue; bl=0 is promoted to a single beat.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state    <= ST_IDLE;
            r_addr_cnt <= '0;
            r_left     <= '0;
            r_ack      <= 1'b0;
            r_lack     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ack   <= 1'b0;
            r_lack  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (wbs_stb_i) begin
                        r_addr_cnt <= wbs_adr_i[SRAM_AW+1:2];
                        r_left     <= (wbs_bl_i == '0) ? BL_ONE : wbs_bl_i;
                        if (!w_hit) begin
                            r_ack  <= 1'b1;
                            r_lack <= 1'b1;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (w_rd_issue) begin
                        r_addr_cnt <= r_addr_cnt + AW_ONE;
                        r_left     <= r_left - BL_ONE;
                    end
                end
                ST_WR_ISS: begin
                    if (w_wr_issue) begin
                        r_left <= r_left - BL_ONE;
                        r_ack  <= 1'b1;
                        r_lack <= w_last_beat;
                    end
                end
                ST_WR_ACK: begin
                    if (wbs_stb_i && !r_lack) r_addr_cnt <= r_addr_cnt + AW_ONE;
                end
                default: ;
            endcase
        end
    end

    ycr_sram_rd_pipe u_rd_pipe (
        .clk         (wb_clk),
        .rst_n       (wb_rst_n),
        .i_issue     (w_rd_issue),
        .i_last      (w_last_beat),
        .i_sram_dout (sram_dout),
        .o_ack       (w_rd_ack),
        .o_lack      (w_rd_lack),
        .o_dat       (w_rd_dat)
    );

    assign wbs_ack_o  = r_ack | w_rd_ack;
    assign wbs_lack_o = r_lack | w_rd_lack;
    assign wbs_err_o  = r_err;
    assign wbs_dat_o  = w_rd_dat;

    assign sram_csb   = ~(w_rd_issue | w_wr_issue);
    assign sram_web   = ~w_wr_issue;
    assign sram_wmask = w_wr_issue ? wbs_sel_i : 4'b0000;
    assign sram_addr  = r_addr_cnt;
    assign sram_din   = w_wr_issue ? wbs_dat_i : 32'h0;

endmodule

// File: tb/tb_ycr_dmem_sram_wbs.sv
// Bench for ycr_dmem_sram_wbs: SRAM behavioural model, word-array reference
// memory, directed bursts followed by randomized bursts.
module tb_ycr_dmem_sram_wbs;
    import ycr_wb::*;

    logic                      wb_clk = 1'b0;
    logic                      wb_rst_n;
    logic                      wbs_stb_i;
    logic [31:0]               wbs_adr_i;
    logic                      wbs_we_i;
    logic [31:0]               wbs_dat_i;
    logic [3:0]                wbs_sel_i;
    logic [YCR_WB_BL_DMEM-1:0] wbs_bl_i;
    logic                      wbs_bry_i;
    logic [31:0]               wbs_dat_o;
    logic                      wbs_ack_o;
    logic                      wbs_lack_o;
    logic                      wbs_err_o;
    logic                      sram_csb;
    logic                      sram_web;
    logic [3:0]                sram_wmask;
    logic [8:0]                sram_addr;
    logic [31:0]               sram_din;
    logic [31:0]               sram_dout;

    logic        bd_we;
    logic [8:0]  bd_addr;
    logic [31:0] bd_data;

    logic [31:0] mem     [512];
    logic [31:0] ref_mem [512];
    logic [31:0] wq[$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 wb_clk = ~wb_clk;

    ycr_dmem_sram_wbs dut (
        .wb_clk     (wb_clk),
        .wb_rst_n   (wb_rst_n),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_bl_i   (wbs_bl_i),
        .wbs_bry_i  (wbs_bry_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_lack_o (wbs_lack_o),
        .wbs_err_o  (wbs_err_o),
        .sram_csb   (sram_csb),
        .sram_web   (sram_web),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    // Single-port SRAM with 1-cycle read latency plus a backdoor load port.
    always @(posedge wb_clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // mode 0: bry always high; 1: bry low for st_len cycles after st_after issues; 2: random bry
    task automatic run_burst(input logic we, input logic [31:0] adr, input int bl,
                             input logic [3:0] sel, input int mode, input int st_after,
                             input int st_len, input bit chk_timing);
        int          beats;
        int          w;
        bit          hit;
        logic [31:0] wd[$];
        logic [31:0] m;
        int n_ack = 0, n_iss = 0, stall = 0, cyc = 0, last_cyc = 0;
        int csb_low = 0, stray = 0, bad = 0;
        bit done = 0;

        beats = (bl == 0) ? 1 : bl;
        hit   = (adr >= 32'h0C00_0000) && (adr < 32'h0C00_0800);
        w     = int'((adr >> 2) % 512);
        for (int k = 0; k < beats; k++) wd.push_back(wq.size() > 0 ? wq.pop_front() : $urandom);

        @(negedge wb_clk);
        wbs_stb_i = 1'b1;
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_bl_i  = 4'(bl);
        wbs_sel_i = sel;
        wbs_dat_i = wd[0];
        while (!done && cyc < 200) begin
            case (mode)
                0: wbs_bry_i = 1'b1;
                1: begin
                    if (n_iss >= st_after && stall < st_len) begin
                        wbs_bry_i = 1'b0;
                        stall++;
                    end else begin
                        wbs_bry_i = 1'b1;
                    end
                end
                default: wbs_bry_i = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (!sram_csb) begin
                csb_low++;
                if (!we) begin
                    if (!sram_web || sram_addr !== 9'((w + n_iss) % 512)) bad++;
                    n_iss++;
                end else begin
                    if (sram_web || sram_wmask !== sel || sram_addr !== 9'((w + n_ack) % 512) ||
                        sram_din !== ((n_ack < beats) ? wd[n_ack] : 32'h0)) bad++;
                end
            end
            @(posedge wb_clk);
            cyc++;
            @(negedge wb_clk);
            if (wbs_ack_o) begin
                if (n_ack == 0 && chk_timing) check("first_ack_cycle", 64'(cyc), hit ? 64'd2 : 64'd1);
                if (!hit) begin
                    check("err_beat", {wbs_lack_o, wbs_err_o, wbs_dat_o}, {1'b1, 1'b1, 32'h0});
                end else if (!we) begin
                    check("rd_beat", {wbs_lack_o, wbs_err_o, wbs_dat_o},
                          {logic'(n_ack == beats - 1), 1'b0, ref_mem[(w + n_ack) % 512]});
                end else begin
                    check("wr_beat", {wbs_lack_o, wbs_err_o}, {logic'(n_ack == beats - 1), 1'b0});
                    if (mode == 0 && n_ack > 0) check("wr_ack_spacing", 64'(cyc - last_cyc), 64'd2);
                end
                n_ack++;
                last_cyc = cyc;
                if (wbs_lack_o) done = 1;
                if (we && n_ack < beats) wbs_dat_i = wd[n_ack];
            end else if (wbs_lack_o || wbs_err_o) begin
                stray++;
            end
        end
        wbs_stb_i = 1'b0;
        wbs_bry_i = 1'b1;

        check("burst_completed", 64'(done), 64'd1);
        check("ack_count", 64'(n_ack), hit ? 64'(beats) : 64'd1);
        check("stray_lack_err", 64'(stray), 64'd0);
        if (!hit) check("err_no_sram", 64'(csb_low), 64'd0);
        else      check("sram_issue_fields", 64'(bad), 64'd0);
        if (hit && we) begin
            for (int k = 0; k < beats; k++) begin
                m = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
                ref_mem[(w + k) % 512] = (ref_mem[(w + k) % 512] & ~m) | (wd[k] & m);
            end
            @(negedge wb_clk);
            for (int k = 0; k < beats; k++)
                check("wr_mem_word", mem[(w + k) % 512], ref_mem[(w + k) % 512]);
        end
    endtask

    initial begin
        wb_rst_n  = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_adr_i = 32'h0;
        wbs_we_i  = 1'b0;
        wbs_dat_i = 32'h0;
        wbs_sel_i = 4'h0;
        wbs_bl_i  = '0;
        wbs_bry_i = 1'b1;
        bd_we     = 1'b0;
        bd_addr   = '0;
        bd_data   = '0;

        #1;
        check("reset_outputs",
              {wbs_ack_o, wbs_lack_o, wbs_err_o, wbs_dat_o, sram_csb, sram_web, sram_wmask},
              {1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0});

        for (int i = 0; i < 512; i++) begin
            @(negedge wb_clk);
            bd_we   = 1'b1;
            bd_addr = 9'(i);
            bd_data = (i == 4) ? 32'hDEAD_BEEF : $urandom;
            ref_mem[i] = bd_data;
        end
        @(negedge wb_clk);
        bd_we = 1'b0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        @(negedge wb_clk);

        run_burst(1'b0, 32'h0C00_0010, 1, 4'hF, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h0C00_07F8, 4, 4'hF, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h0C00_0100, 4, 4'hF, 1, 2, 3, 1'b1);
        wq.push_back(32'h1122_3344);
        wq.push_back(32'h5566_7788);
        run_burst(1'b1, 32'h0C00_0020, 2, 4'b0110, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h0C00_0020, 2, 4'hF, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h1000_0000, 4, 4'hF, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h0C00_0013, 3, 4'hF, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h0C00_0400, 15, 4'hF, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h0C00_0200, 0, 4'hF, 0, 0, 0, 1'b1);
        run_burst(1'b1, 32'h0C00_07E0, 15, 4'b1001, 0, 0, 0, 1'b1);
        run_burst(1'b0, 32'h0C00_07E0, 15, 4'hF, 2, 0, 0, 1'b0);
        run_burst(1'b1, 32'h0BFF_FFFC, 2, 4'hF, 0, 0, 0, 1'b1);

        // Reset in the middle of an 8-beat read
        @(negedge wb_clk);
        wbs_stb_i = 1'b1;
        wbs_adr_i = 32'h0C00_0300;
        wbs_we_i  = 1'b0;
        wbs_bl_i  = 4'd8;
        wbs_bry_i = 1'b1;
        repeat (4) @(negedge wb_clk);
        check("mid_burst_ack_before_reset", 64'(wbs_ack_o), 64'd1);
        #2 wb_rst_n = 1'b0;
        #1;
        check("mid_burst_reset_outputs",
              {wbs_ack_o, wbs_lack_o, wbs_err_o, wbs_dat_o, sram_csb, sram_web, sram_wmask},
              {1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'h0});
        @(negedge wb_clk);
        wbs_stb_i = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_rst_n = 1'b1;
        run_burst(1'b0, 32'h0C00_0300, 2, 4'hF, 0, 0, 0, 1'b1);

        for (int r = 0; r < 25; r++) begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = 32'h0C00_0800 + 32'($urandom_range(0, 4095));
            else a = 32'h0C00_0000 + 32'($urandom_range(0, 511) << 2) + 32'($urandom_range(0, 3));
            run_burst(logic'($urandom_range(0, 1)), a, $urandom_range(0, 15),
                      4'($urandom_range(0, 15)), 2, 0, 0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
